// File: rtl/gmii_gen_pkg.sv
// Shared constants, state encoding and LFSR step for the GMII frame generator.
package gmii_gen_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_SFD      = 3'd2;
    localparam logic [2:0] ST_PAYLOAD  = 3'd3;
    localparam logic [2:0] ST_IFG      = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        PREAMBLE = ST_PREAMBLE,
        SFD      = ST_SFD,
        PAYLOAD  = ST_PAYLOAD,
        IFG      = ST_IFG
    } state_t;

    typedef enum logic {
        PAT_INC  = 1'b0,
        PAT_LFSR = 1'b1
    } pattern_t;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/gmii_payload_gen.sv
// Payload byte source: data_byte always holds the next payload byte to transmit.
module gmii_payload_gen
    import gmii_gen_pkg::*;
(
    input  logic       GTX_CLK,
    input  logic       RESET,
    input  logic       load,
    input  logic       advance,
    input  logic       mode,
    input  logic [7:0] seed,
    output logic [7:0] data_byte
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge GTX_CLK) begin
        if (RESET) begin
            data_byte <= '0;
        end else if (load) begin
            data_byte <= (mode == PAT_LFSR && seed == 8'h00) ? 8'h01 : seed;
        end else if (advance) begin
            data_byte <= (mode == PAT_LFSR) ? lfsr_next(data_byte) : data_byte + 8'd1;
        end
    end

endmodule

// File: rtl/gmii_frame_gen.sv
// GMII transmit frame generator: preamble, SFD, patterned payload, IFG, in bursts.
// Optional TX_ER injection is built when GMII_GEN_ERR_INJECT_EN is defined.
module gmii_frame_gen
    import gmii_gen_pkg::*;
#(
    parameter int PRE_LEN = 7,
    parameter int IFG_LEN = 12,
    parameter int LEN_W   = 11,
    parameter int MIN_LEN = 1,
    parameter int CNT_W   = 8
) (
    input  logic             GTX_CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [CNT_W-1:0] frame_cnt,
    input  logic             pattern_sel,
    input  logic [7:0]       seed,
`ifdef GMII_GEN_ERR_INJECT_EN
    input  logic             err_inj,
    input  logic [LEN_W-1:0] err_pos,
`endif
    output logic [7:0]       TXD,
    output logic             TX_EN,
    output logic             TX_ER,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int CW = (LEN_W > 8) ? LEN_W : 8;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_eff;
    logic [CNT_W-1:0] burst_q;
    logic             mode_q;
    logic [7:0]       seed_q;
    logic [7:0]       pay_byte;
    logic             pay_load;
    logic             pay_advance;

    assign len_eff = (frame_len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : frame_len;

    // The pattern is reloaded throughout every preamble so each frame restarts from seed.
    assign pay_load    = (state == PREAMBLE);
    assign pay_advance = (state == SFD) || (state == PAYLOAD && cnt != '0);

    gmii_payload_gen u_payload (
        .GTX_CLK   (GTX_CLK),
        .RESET     (RESET),
        .load      (pay_load),
        .advance   (pay_advance),
        .mode      (mode_q),
        .seed      (seed_q),
        .data_byte (pay_byte)
    );

    // cnt holds the cycles remaining in the current state after the one on the wire.
    always_ff @(posedge GTX_CLK) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            len_q       <= '0;
            burst_q     <= '0;
            mode_q      <= 1'b0;
            seed_q      <= '0;
            TXD         <= '0;
            TX_EN       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q       <= len_eff;
                        burst_q     <= frame_cnt;
                        mode_q      <= pattern_sel;
                        seed_q      <= seed;
                        frames_sent <= '0;
                        busy        <= 1'b1;
                        state       <= PREAMBLE;
                        cnt         <= CW'(PRE_LEN - 1);
                        TX_EN       <= 1'b1;
                        TXD         <= PREAMBLE_BYTE;
                    end
                end
                PREAMBLE: begin
                    if (cnt == '0) begin
                        state <= SFD;
                        TXD   <= SFD_BYTE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SFD: begin
                    state <= PAYLOAD;
                    TXD   <= pay_byte;
                    cnt   <= CW'(len_q) - 1'b1;
                end
                PAYLOAD: begin
                    if (cnt == '0) begin
                        state       <= IFG;
                        TX_EN       <= 1'b0;
                        TXD         <= '0;
                        frames_sent <= frames_sent + 1'b1;
                        cnt         <= CW'(IFG_LEN - 1);
                    end else begin
                        TXD <= pay_byte;
                        cnt <= cnt - 1'b1;
                    end
                end
                IFG: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (stop || (burst_q != '0 && frames_sent == burst_q)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= PREAMBLE;
                        cnt   <= CW'(PRE_LEN - 1);
                        TX_EN <= 1'b1;
                        TXD   <= PREAMBLE_BYTE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GMII_GEN_ERR_INJECT_EN
    logic             err_inj_q;
    logic [LEN_W-1:0] err_pos_q;

    // The index of the byte about to be driven is 0 from SFD, else len_q - cnt.
    always_ff @(posedge GTX_CLK) begin
        if (RESET) begin
            err_inj_q <= 1'b0;
            err_pos_q <= '0;
            TX_ER     <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                err_inj_q <= err_inj;
                err_pos_q <= err_pos;
            end
            TX_ER <= err_inj_q &&
                     ((state == SFD && err_pos_q == '0) ||
                      (state == PAYLOAD && cnt != '0 &&
                       CW'(err_pos_q) == (CW'(len_q) - cnt)));
        end
    end
`else
    assign TX_ER = 1'b0;
`endif

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Randomized self-checking bench for gmii_frame_gen against a per-cycle frame model.
module tb_gmii_frame_gen;

    localparam int PRE_LEN = 7;
    localparam int IFG_LEN = 12;
    localparam int LEN_W   = 11;
    localparam int MIN_LEN = 1;
    localparam int CNT_W   = 8;

    logic             GTX_CLK = 1'b0;
    logic             RESET;
    logic             start;
    logic             stop;
    logic [LEN_W-1:0] frame_len;
    logic [CNT_W-1:0] frame_cnt;
    logic             pattern_sel;
    logic [7:0]       seed;
`ifdef GMII_GEN_ERR_INJECT_EN
    logic             err_inj;
    logic [LEN_W-1:0] err_pos;
`endif
    logic [7:0]       TXD;
    logic             TX_EN;
    logic             TX_ER;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frames_sent;

    logic [19:0]      obs;
    int               n_cmp = 0;
    int               n_bad = 0;

    assign obs = {busy, done, TX_EN, TX_ER, TXD, frames_sent};

    gmii_frame_gen #(
        .PRE_LEN (PRE_LEN),
        .IFG_LEN (IFG_LEN),
        .LEN_W   (LEN_W),
        .MIN_LEN (MIN_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .GTX_CLK     (GTX_CLK),
        .RESET       (RESET),
        .start       (start),
        .stop        (stop),
        .frame_len   (frame_len),
        .frame_cnt   (frame_cnt),
        .pattern_sel (pattern_sel),
        .seed        (seed),
`ifdef GMII_GEN_ERR_INJECT_EN
        .err_inj     (err_inj),
        .err_pos     (err_pos),
`endif
        .TXD         (TXD),
        .TX_EN       (TX_EN),
        .TX_ER       (TX_ER),
        .busy        (busy),
        .done        (done),
        .frames_sent (frames_sent)
    );

    always #4 GTX_CLK = ~GTX_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Payload byte k of a frame, straight from the pattern definitions.
    function automatic logic [7:0] model_byte(input bit pat, input logic [7:0] sd, input int k);
        logic [7:0] s;
        if (!pat) return 8'((int'(sd) + k) % 256);
        s = (sd == 8'h00) ? 8'h01 : sd;
        // feedback taps from the x^8, x^6, x^5, x^4 terms
        repeat (k) s = {s[6:0], s[8-1] ^ s[6-1] ^ s[5-1] ^ s[4-1]};
        return s;
    endfunction

    function automatic int frame_period(input int len);
        int l = (len < MIN_LEN) ? MIN_LEN : len;
        return PRE_LEN + 1 + l + IFG_LEN;
    endfunction

    // Expected {busy,done,TX_EN,TX_ER,TXD,frames_sent} for cycle c after the start edge.
    function automatic logic [19:0] model_vec(input int c, input int l, input int nfr,
                                              input bit pat, input logic [7:0] sd,
                                              input bit inj, input int pos);
        int         p = PRE_LEN + 1 + l + IFG_LEN;
        int         t = nfr * p;
        int         f;
        int         o;
        logic       b = 1'b0;
        logic       dn = 1'b0;
        logic       en = 1'b0;
        logic       er = 1'b0;
        logic [7:0] d = 8'h00;
        int         fs;
        if (c < t) begin
            f  = c / p;
            o  = c % p;
            b  = 1'b1;
            fs = f;
            if (o < PRE_LEN) begin
                en = 1'b1; d = 8'h55;
            end else if (o == PRE_LEN) begin
                en = 1'b1; d = 8'hD5;
            end else if (o < PRE_LEN + 1 + l) begin
                en = 1'b1;
                d  = model_byte(pat, sd, o - PRE_LEN - 1);
                er = inj && (o - PRE_LEN - 1 == pos);
            end else begin
                fs = f + 1;
            end
        end else begin
            dn = (c == t);
            fs = nfr;
        end
        return {b, dn, en, er, d, CNT_W'(fs)};
    endfunction

    // One burst from start to one cycle past done; stop_at < 0 means stop never raised.
    task automatic run_burst(input int len, input int cnt, input bit pat, input logic [7:0] sd,
                             input int stop_at, input bit poke, input bit inj, input int pos);
        int l = (len < MIN_LEN) ? MIN_LEN : len;
        int p = frame_period(len);
        int nfr;
        if (stop_at < 0) begin
            nfr = cnt;
        end else begin
            nfr = 1;
            while (nfr * p - 1 < stop_at) nfr++;
            if (cnt != 0 && cnt < nfr) nfr = cnt;
        end
        @(negedge GTX_CLK);
        frame_len   = LEN_W'(len);
        frame_cnt   = CNT_W'(cnt);
        pattern_sel = pat;
        seed        = sd;
`ifdef GMII_GEN_ERR_INJECT_EN
        err_inj     = inj;
        err_pos     = LEN_W'(pos);
`endif
        start       = 1'b1;
        @(negedge GTX_CLK);
        start       = 1'b0;
        frame_len   = LEN_W'($urandom_range(0, 60));
        frame_cnt   = CNT_W'($urandom);
        pattern_sel = 1'($urandom);
        seed        = 8'($urandom);
`ifdef GMII_GEN_ERR_INJECT_EN
        err_pos     = LEN_W'($urandom_range(0, 10));
`endif
        for (int c = 0; c <= nfr * p + 1; c++) begin
            check($sformatf("len%0d_cyc%0d", l, c), 32'(obs), 32'(model_vec(c, l, nfr, pat, sd, inj, pos)));
            if (stop_at >= 0 && c == stop_at) stop = 1'b1;
            start = (poke && c == 2);
            @(negedge GTX_CLK);
        end
        stop  = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int len;
        int cnt;
        int sa;
        RESET       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        frame_len   = '0;
        frame_cnt   = '0;
        pattern_sel = 1'b0;
        seed        = '0;
`ifdef GMII_GEN_ERR_INJECT_EN
        err_inj     = 1'b0;
        err_pos     = '0;
`endif
        repeat (3) @(negedge GTX_CLK);
        check("reset_state", 32'(obs), 32'd0);
        RESET = 1'b0;
        @(negedge GTX_CLK);
        check("idle_after_reset", 32'(obs), 32'd0);

        run_burst(4, 1, 1'b0, 8'hF0, -1, 1'b0, 1'b0, 0);
        run_burst(3, 1, 1'b0, 8'hFE, -1, 1'b0, 1'b0, 0);
        run_burst(3, 1, 1'b1, 8'h00, -1, 1'b0, 1'b0, 0);
        run_burst(0, 2, 1'b0, 8'h10, -1, 1'b0, 1'b0, 0);

        // continuous burst, stop raised mid-payload of the third frame, stray start mid-burst
        len = 9;
        run_burst(len, 0, 1'b1, 8'h5A, 2 * frame_period(len) + PRE_LEN + 1 + 4, 1'b1, 1'b0, 0);

        // reset in the middle of a payload, together with a start request
        @(negedge GTX_CLK);
        frame_len = LEN_W'(8);
        frame_cnt = '0;
        start     = 1'b1;
        @(negedge GTX_CLK);
        start = 1'b0;
        repeat (PRE_LEN + 1 + 3) @(negedge GTX_CLK);
        check("pre_reset_txen", 32'(TX_EN), 32'd1);
        RESET = 1'b1;
        start = 1'b1;
        @(negedge GTX_CLK);
        check("reset_mid_frame", 32'(obs), 32'd0);
        RESET = 1'b0;
        start = 1'b0;
        @(negedge GTX_CLK);
        check("idle_after_mid_reset", 32'(obs), 32'd0);
        run_burst(5, 2, 1'b0, 8'h33, -1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 10; i++) begin
            len = $urandom_range(0, 30);
            cnt = $urandom_range(0, 3);
            sa  = -1;
            if (cnt == 0 || $urandom_range(0, 3) == 0)
                sa = $urandom_range(0, 3 * frame_period(len) - 1);
            run_burst(len, cnt, 1'($urandom), 8'($urandom), sa, 1'($urandom), 1'b0, 0);
        end

`ifdef GMII_GEN_ERR_INJECT_EN
        run_burst(4, 2, 1'b0, 8'hA0, -1, 1'b0, 1'b1, 2);
        run_burst(3, 1, 1'b1, 8'h77, -1, 1'b0, 1'b1, 3);
        run_burst(6, 1, 1'b0, 8'h01, -1, 1'b0, 1'b1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
